dcache_flush_engine: RTL and testbench
======================================

Name: dcache_flush_engine

Overview:
- Hardware write-back/invalidate sequencer for the CPU's set-associative data cache.
- On request, walks every (set, way) entry of the dcache SRAM and writes each valid+dirty line to Data_Memory through the existing enable/write/ack handshake.
- Then clears the dirty bit, and the valid bit too in invalidate mode.
- Sits beside dcache, arbitrated onto the memory port; flush_busy_o is ORed into the CPU stall.

Parameters:
- NUM_SETS, 16, cache sets; power of 2, at least 2.
- NUM_WAYS, 2, ways per set; power of 2, at least 1.
- LINE_BITS, 256, cache line width.
- ADDR_BITS, 32, byte address width.
- OFFSET_BITS, 5, log2 of line bytes.
- TAG_BITS, 25, SRAM tag word: bit[TAG_BITS-1]=valid, bit[TAG_BITS-2]=dirty, low ATAG=ADDR_BITS-log2(NUM_SETS)-OFFSET_BITS bits = address tag (23 at defaults).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset, synchronous, active-low.
- flush_req_i  in  1  start pulse or level; sampled only in IDLE.
- invalidate_i  in  1  mode, latched at start: 1 = flush+invalidate, 0 = clean only.
- flush_busy_o  out  1  high from the cycle after start through DONE.
- flush_done_o  out  1  one-cycle pulse in DONE.
- wb_count_o  out  16  lines written back in the last/current flush; saturates at 16'hFFFF.
- sram_idx_o  out  log2(NUM_SETS)  set index for read/write.
- sram_way_o  out  max(1,log2(NUM_WAYS))  way select.
- sram_tag_i  in  TAG_BITS  tag word; valid one cycle after index/way applied.
- sram_data_i  in  LINE_BITS  line data; same timing as sram_tag_i.
- sram_we_o  out  1  tag write strobe (tag only, data untouched).
- sram_tag_o  out  TAG_BITS  tag word written when sram_we_o=1.
- mem_enable_o  out  1  memory request.
- mem_write_o  out  1  always 1 while mem_enable_o=1.
- mem_addr_o  out  ADDR_BITS  {tag[ATAG-1:0], idx, OFFSET_BITS'b0}.
- mem_data_o  out  LINE_BITS  captured line.
- mem_ack_i  in  1  memory completion, one cycle.

Behaviour:
- Reset (rst_i=0 at posedge):
  - State goes to IDLE; idx, way and wb_count clear to 0.
  - All outputs go to 0, including sram_idx_o and sram_way_o.
  - Reset mid-operation abandons any outstanding write and issues no SRAM write; Data_Memory is reset by the same rst_i.
- States: IDLE, RD, CHK, WB, UPD, NEXT, DONE.
- IDLE:
  - On flush_req_i=1, latch invalidate_i, clear wb_count, set idx=way=0, go to RD.
  - flush_req_i is ignored in every other state; no queuing.
- RD: drive sram_idx_o/sram_way_o (they stay stable through UPD); go to CHK.
- CHK: register sram_tag_i and sram_data_i into line buffers, then:
  - valid&dirty: go to WB.
  - otherwise, valid&invalidate: go to UPD.
  - otherwise: go to NEXT.
- WB:
  - mem_enable_o=mem_write_o=1, with address and data from the buffers, held stable every cycle until mem_ack_i=1.
  - On ack: increment wb_count and go to UPD. mem_enable_o drops the cycle after ack.
  - No timeout; latency is whatever Data_Memory takes (~10 cycles).
- UPD:
  - sram_we_o=1 for exactly one cycle; sram_tag_o = buffered tag with dirty=0, and valid=0 if invalidate.
  - Address-tag bits are preserved. Go to NEXT.
- NEXT:
  - way+1; when way wraps to 0, idx+1.
  - After (NUM_SETS-1, NUM_WAYS-1), go to DONE; else go to RD.
- DONE: flush_done_o=1 and flush_busy_o=1 for one cycle, then IDLE.
- mem_ack_i outside WB is ignored. wb_count_o holds its value after DONE until the next start.
- Per-entry cost:
  - Clean: 3 cycles (RD, CHK, NEXT).
  - Invalidate-only: 4 cycles.
  - Dirty: 4 + memory latency (cycles in WB counted from enable to ack inclusive).
- Invalid-but-dirty entries (tag valid=0) are never written back.

Decomposition:
- Package dcache_pkg:
  - State enum.
  - VALID_BIT/DIRTY_BIT position functions of TAG_BITS.
  - Localparams IDX_W=$clog2(NUM_SETS) and WAY_W.
  - Address-compose function {atag, idx, offset0}.
- Sub-module flush_walker: idx/way counter with inc and last flags. Reusable by a future prefetch/scrub engine.

Test Plan:
- All 32 entries invalid, flush_req_i pulse at cycle 0 -> mem_enable_o never asserts; flush_done_o pulses 97 cycles after the sampling edge; wb_count_o=0.
- Set 3 way 1 tag={1,1,23'h40}, line=256'hECFA..ECFA; Data_Memory ack after 10 cycles -> mem_addr_o=32'h00008060 with data ECFA.. stable until ack. SRAM tag for set 3 way 1 becomes {1,0,23'h40}; wb_count_o=1.
- Same setup with invalidate_i=1 -> written tag={0,0,23'h40}. A valid clean entry at set 0 way 0 becomes invalid with no memory write.
- Dirty lines at set 0 way 0 and set 15 way 1 -> exactly two memory writes, in that order; wb_count_o=2; memory words updated at the composed addresses.
- Drop rst_i during WB of the first dirty line -> next cycle all outputs are 0 with sram_we_o never pulsed; a re-issued flush completes normally.
- flush_req_i held high through the whole flush -> exactly one flush, then a second starts the cycle after return to IDLE; a mem_ack_i glitch in CHK has no effect.

Source files
------------

// File: rtl/dcache_flush_engine_pkg.sv
// Shared types and helpers for the dcache flush/invalidate sequencer.
// Tag-word bit positions and the write-back address layout live here so other engines agree on them.
package dcache_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_CHK,
    ST_WB,
    ST_UPD,
    ST_NEXT,
    ST_DONE
  } flush_state_e;

  localparam int NUM_SETS_DEF    = 16;
  localparam int NUM_WAYS_DEF    = 2;
  localparam int LINE_BITS_DEF   = 256;
  localparam int ADDR_BITS_DEF   = 32;
  localparam int OFFSET_BITS_DEF = 5;
  localparam int TAG_BITS_DEF    = 25;

  // A direct-mapped cache still needs a one-bit way select.
  function automatic int way_width(input int num_ways);
    return (num_ways > 1) ? $clog2(num_ways) : 1;
  endfunction

  localparam int IDX_W = $clog2(NUM_SETS_DEF);
  localparam int WAY_W = way_width(NUM_WAYS_DEF);

  function automatic int valid_bit(input int tag_bits);
    return tag_bits - 1;
  endfunction

  function automatic int dirty_bit(input int tag_bits);
    return tag_bits - 2;
  endfunction

  // Line address {atag, idx, zero offset}; the caller truncates to its address width.
  function automatic logic [63:0] compose_addr(input logic [63:0] atag,
                                               input logic [63:0] idx,
                                               input int          idx_w,
                                               input int          off_w);
    return (atag << (idx_w + off_w)) | (idx << off_w);
  endfunction

endpackage

// File: rtl/dcache_flush_engine_if.sv
// Tag/data SRAM port and Data_Memory write port used by the flush engine.
// The master side is the engine; the slave side is the dcache SRAM plus the memory arbiter.
interface dcache_flush_engine_if #(
  parameter int NUM_SETS  = dcache_pkg::NUM_SETS_DEF,
  parameter int NUM_WAYS  = dcache_pkg::NUM_WAYS_DEF,
  parameter int LINE_BITS = dcache_pkg::LINE_BITS_DEF,
  parameter int ADDR_BITS = dcache_pkg::ADDR_BITS_DEF,
  parameter int TAG_BITS  = dcache_pkg::TAG_BITS_DEF
);
  localparam int IW = $clog2(NUM_SETS);
  localparam int WW = dcache_pkg::way_width(NUM_WAYS);

  logic [IW-1:0]        sram_idx;
  logic [WW-1:0]        sram_way;
  logic [TAG_BITS-1:0]  sram_tag_rd;
  logic [LINE_BITS-1:0] sram_data;
  logic                 sram_we;
  logic [TAG_BITS-1:0]  sram_tag_wr;

  logic                 mem_enable;
  logic                 mem_write;
  logic [ADDR_BITS-1:0] mem_addr;
  logic [LINE_BITS-1:0] mem_data;
  logic                 mem_ack;

  modport master (
    output sram_idx, sram_way, sram_we, sram_tag_wr,
    output mem_enable, mem_write, mem_addr, mem_data,
    input  sram_tag_rd, sram_data, mem_ack
  );

  modport slave (
    input  sram_idx, sram_way, sram_we, sram_tag_wr,
    input  mem_enable, mem_write, mem_addr, mem_data,
    output sram_tag_rd, sram_data, mem_ack
  );

endinterface

// File: rtl/dcache_flush_engine_walker.sv
// Set/way walker: way is the fast index, set the slow one; 'last' flags the final entry.
// Kept generic so a scrub or prefetch engine can reuse the same traversal order.
module flush_walker
  import dcache_pkg::*;
#(
  parameter  int NUM_SETS = NUM_SETS_DEF,
  parameter  int NUM_WAYS = NUM_WAYS_DEF,
  localparam int IW       = $clog2(NUM_SETS),
  localparam int WW       = way_width(NUM_WAYS)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          clr,
  input  logic          inc,
  output logic [IW-1:0] idx,
  output logic [WW-1:0] way,
  output logic          last
);

  always_ff @(posedge clk_i) begin
    if (!rst_i || clr) begin
      idx <= '0;
      way <= '0;
    end else if (inc) begin
      if (way == WW'(NUM_WAYS - 1)) begin
        way <= '0;
        idx <= idx + IW'(1);
      end else begin
        way <= way + WW'(1);
      end
    end
  end

  assign last = (idx == IW'(NUM_SETS - 1)) && (way == WW'(NUM_WAYS - 1));

endmodule

// File: rtl/dcache_flush_engine.sv
// Walks every dcache entry, writes valid+dirty lines back to Data_Memory, then clears
// dirty (and valid in invalidate mode) in the tag SRAM.
module dcache_flush_engine
  import dcache_pkg::*;
#(
  parameter int NUM_SETS    = NUM_SETS_DEF,
  parameter int NUM_WAYS    = NUM_WAYS_DEF,
  parameter int LINE_BITS   = LINE_BITS_DEF,
  parameter int ADDR_BITS   = ADDR_BITS_DEF,
  parameter int OFFSET_BITS = OFFSET_BITS_DEF,
  parameter int TAG_BITS    = TAG_BITS_DEF
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        flush_req_i,
  input  logic        invalidate_i,
  output logic        flush_busy_o,
  output logic        flush_done_o,
  output logic [15:0] wb_count_o,
  dcache_flush_engine_if.master bus
);

  localparam int IW   = $clog2(NUM_SETS);
  localparam int WW   = way_width(NUM_WAYS);
  localparam int ATAG = ADDR_BITS - IW - OFFSET_BITS;
  localparam int VB   = valid_bit(TAG_BITS);
  localparam int DB   = dirty_bit(TAG_BITS);

  flush_state_e         state, state_n;
  logic                 inv_q;
  logic [15:0]          wb_count;
  logic [TAG_BITS-1:0]  tag_q;
  logic [LINE_BITS-1:0] data_q;
  logic [TAG_BITS-1:0]  upd_tag;
  logic [ADDR_BITS-1:0] wb_addr;
  logic [IW-1:0]        idx;
  logic [WW-1:0]        way;
  logic                 last;
  logic                 start;

  assign start = (state == ST_IDLE) && flush_req_i;

  flush_walker #(
    .NUM_SETS (NUM_SETS),
    .NUM_WAYS (NUM_WAYS)
  ) u_walker (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr   (start),
    .inc   (state == ST_NEXT),
    .idx   (idx),
    .way   (way),
    .last  (last)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state    <= ST_IDLE;
      inv_q    <= 1'b0;
      wb_count <= '0;
      tag_q    <= '0;
      data_q   <= '0;
    end else begin
      state <= state_n;
      if (start) begin
        inv_q    <= invalidate_i;
        wb_count <= '0;
      end
      if (state == ST_CHK) begin
        tag_q  <= bus.sram_tag_rd;
        data_q <= bus.sram_data;
      end
      if (state == ST_WB && bus.mem_ack && wb_count != 16'hFFFF) begin
        wb_count <= wb_count + 16'd1;
      end
    end
  end

  // Only the state bits change; the address tag and any spare bits are written back untouched.
  always_comb begin
    upd_tag     = tag_q;
    upd_tag[DB] = 1'b0;
    if (inv_q) begin
      upd_tag[VB] = 1'b0;
    end
  end

  assign wb_addr = ADDR_BITS'(compose_addr(64'(tag_q[ATAG-1:0]), 64'(idx), IW, OFFSET_BITS));

  // The CHK decision uses the live SRAM word, which is also being captured this cycle.
  always_comb begin
    state_n         = state;
    flush_busy_o    = (state != ST_IDLE);
    flush_done_o    = 1'b0;
    bus.sram_we     = 1'b0;
    bus.sram_tag_wr = '0;
    bus.mem_enable  = 1'b0;
    bus.mem_write   = 1'b0;
    bus.mem_addr    = '0;
    bus.mem_data    = '0;
    case (state)
      ST_IDLE: begin
        if (flush_req_i) begin
          state_n = ST_RD;
        end
      end
      ST_RD: begin
        state_n = ST_CHK;
      end
      ST_CHK: begin
        if (bus.sram_tag_rd[VB] && bus.sram_tag_rd[DB]) begin
          state_n = ST_WB;
        end else if (bus.sram_tag_rd[VB] && inv_q) begin
          state_n = ST_UPD;
        end else begin
          state_n = ST_NEXT;
        end
      end
      ST_WB: begin
        bus.mem_enable = 1'b1;
        bus.mem_write  = 1'b1;
        bus.mem_addr   = wb_addr;
        bus.mem_data   = data_q;
        if (bus.mem_ack) begin
          state_n = ST_UPD;
        end
      end
      ST_UPD: begin
        bus.sram_we     = 1'b1;
        bus.sram_tag_wr = upd_tag;
        state_n         = ST_NEXT;
      end
      ST_NEXT: begin
        state_n = last ? ST_DONE : ST_RD;
      end
      ST_DONE: begin
        flush_done_o = 1'b1;
        state_n      = ST_IDLE;
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  assign bus.sram_idx = idx;
  assign bus.sram_way = way;
  assign wb_count_o   = wb_count;

endmodule

// File: tb/tb_dcache_flush_engine.sv
// Bench for dcache_flush_engine: SRAM and Data_Memory models, a per-flush reference model
// that predicts write-backs, final tags and busy length, and a negedge scoreboard monitor.
module tb_dcache_flush_engine;
  import dcache_pkg::*;

  localparam int NS = NUM_SETS_DEF;
  localparam int NW = NUM_WAYS_DEF;

  typedef struct {
    logic [31:0]  addr;
    logic [255:0] data;
  } wb_t;

  typedef struct {
    int wbs;
    int cycles;
  } done_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush_req = 1'b0;
  logic        invalidate = 1'b0;
  logic        flush_busy;
  logic        flush_done;
  logic [15:0] wb_count;

  dcache_flush_engine_if bus ();

  dcache_flush_engine dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .flush_req_i  (flush_req),
    .invalidate_i (invalidate),
    .flush_busy_o (flush_busy),
    .flush_done_o (flush_done),
    .wb_count_o   (wb_count),
    .bus          (bus)
  );

  always #5 clk = ~clk;

  wb_t          exp_wb[$];
  wb_t          exp_log[$];
  wb_t          wr_log[$];
  done_t        exp_done[$];
  logic [24:0]  init_tag [NS][NW];
  logic [24:0]  m_tag    [NS][NW];
  logic [24:0]  tag_mem  [NS][NW];
  logic [255:0] init_data[NS][NW];
  logic [255:0] data_mem [NS][NW];
  logic [24:0]  rd_tag;
  logic [255:0] rd_data;
  logic         load = 1'b0;
  logic         ack_q;
  logic         glitch = 1'b0;
  int           lat = 10;
  int           cnt;
  int           n_checks = 0;
  int           n_pass = 0;
  int           done_cnt = 0;
  int           we_cnt = 0;
  int           busy_cycles = 0;
  int           last_busy = 0;
  int           last_wbs = 0;

  assign bus.sram_tag_rd = rd_tag;
  assign bus.sram_data   = rd_data;
  assign bus.mem_ack     = ack_q | glitch;

  // Tag/data SRAM with one-cycle registered read.
  always @(posedge clk) begin
    if (load) begin
      tag_mem  <= init_tag;
      data_mem <= init_data;
    end else if (bus.sram_we) begin
      tag_mem[bus.sram_idx][bus.sram_way] <= bus.sram_tag_wr;
    end
    rd_tag  <= tag_mem[bus.sram_idx][bus.sram_way];
    rd_data <= data_mem[bus.sram_idx][bus.sram_way];
  end

  // Data_Memory: ack arrives in the lat-th cycle of an enable, write logged on ack.
  always @(posedge clk) begin
    if (!rst) begin
      ack_q <= 1'b0;
      cnt   <= 0;
      wr_log.delete();
    end else if (bus.mem_enable && !ack_q) begin
      if (cnt == lat - 2) begin
        ack_q <= 1'b1;
        cnt   <= 0;
      end else begin
        cnt <= cnt + 1;
      end
    end else begin
      if (bus.mem_enable && ack_q) begin
        wr_log.push_back('{addr: bus.mem_addr, data: bus.mem_data});
      end
      ack_q <= 1'b0;
    end
  end

  // Stray one-cycle acks whenever no write is in flight.
  initial begin
    forever begin
      @(negedge clk);
      glitch = !bus.mem_enable && ($urandom_range(0, 3) == 0);
    end
  end

  task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic reportFail(input string name);
    n_checks++;
    $display("[TB] FAIL %s: event occurred, expected none", name);
  endtask

  // Scoreboard monitor: write-back cycles and done pulses are popped against predictions.
  always @(negedge clk) begin
    done_t d;
    if (bus.mem_enable) begin
      if (exp_wb.size() == 0) begin
        reportFail("unexpected_mem_write");
      end else begin
        checkOutput("wb_addr", 256'(bus.mem_addr), 256'(exp_wb[0].addr));
        checkOutput("wb_data", bus.mem_data, exp_wb[0].data);
        checkOutput("wb_write", 256'(bus.mem_write), 256'(1));
        if (ack_q) begin
          void'(exp_wb.pop_front());
        end
      end
    end
    if (bus.sram_we) begin
      we_cnt++;
    end
    busy_cycles = flush_busy ? busy_cycles + 1 : 0;
    if (flush_done) begin
      done_cnt++;
      last_busy = busy_cycles;
      if (exp_done.size() == 0) begin
        reportFail("unexpected_done");
      end else begin
        d = exp_done.pop_front();
        checkOutput("done_wb_count", 256'(wb_count), 256'(d.wbs));
        checkOutput("busy_cycles", 256'(busy_cycles), 256'(d.cycles));
      end
    end
  end

  // Reference model of one flush over m_tag: predicted writes, tag updates and cycle cost.
  task automatic predict(input bit inv, input int l);
    int   wbs = 0;
    int   cyc = 0;
    logic [24:0] t;
    wb_t  e;
    for (int s = 0; s < NS; s++) begin
      for (int w = 0; w < NW; w++) begin
        t = m_tag[s][w];
        if (t[24] && t[23]) begin
          e.addr = 32'(t[22:0]) * 32'd512 + 32'(s * 32);
          e.data = init_data[s][w];
          exp_wb.push_back(e);
          exp_log.push_back(e);
          wbs++;
          cyc += 4 + l;
          m_tag[s][w] = {!inv, 1'b0, t[22:0]};
        end else if (t[24] && inv) begin
          cyc += 4;
          m_tag[s][w] = {2'b00, t[22:0]};
        end else begin
          cyc += 3;
        end
      end
    end
    if (wbs > 65535) wbs = 65535;
    last_wbs = wbs;
    exp_done.push_back('{wbs: wbs, cycles: cyc + 1});
  endtask

  task automatic applyReset();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    exp_wb.delete();
    exp_log.delete();
    exp_done.delete();
  endtask

  task automatic applyStimulus(input bit inv, input int l, input int nflush, input bit hold);
    applyReset();
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    m_tag = init_tag;
    lat = l;
    invalidate = inv;
    for (int i = 0; i < nflush; i++) predict(inv, l);
    flush_req = 1'b1;
    if (!hold) begin
      @(negedge clk);
      flush_req = 1'b0;
    end
  endtask

  task automatic waitDone(input int target);
    int k = 0;
    while (done_cnt < target && k < 3000) begin
      @(negedge clk);
      #1;
      k++;
    end
    if (done_cnt < target) begin
      reportFail("done_timeout");
    end
  endtask

  task automatic checkFlush(input string tag);
    for (int s = 0; s < NS; s++)
      for (int w = 0; w < NW; w++)
        checkOutput({tag, "_tag"}, 256'(tag_mem[s][w]), 256'(m_tag[s][w]));
    checkOutput({tag, "_nwrites"}, 256'(wr_log.size()), 256'(exp_log.size()));
    for (int i = 0; i < wr_log.size() && i < exp_log.size(); i++) begin
      checkOutput({tag, "_mem_addr"}, 256'(wr_log[i].addr), 256'(exp_log[i].addr));
      checkOutput({tag, "_mem_word"}, wr_log[i].data, exp_log[i].data);
    end
    checkOutput({tag, "_wb_hold"}, 256'(wb_count), 256'(last_wbs));
    checkOutput({tag, "_queue_drained"}, 256'(exp_wb.size()), 256'(0));
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, "_busy"}, 256'(flush_busy), 256'(0));
    checkOutput({tag, "_done"}, 256'(flush_done), 256'(0));
    checkOutput({tag, "_wb_count"}, 256'(wb_count), 256'(0));
    checkOutput({tag, "_idx"}, 256'(bus.sram_idx), 256'(0));
    checkOutput({tag, "_way"}, 256'(bus.sram_way), 256'(0));
    checkOutput({tag, "_we"}, 256'(bus.sram_we), 256'(0));
    checkOutput({tag, "_tag_wr"}, 256'(bus.sram_tag_wr), 256'(0));
    checkOutput({tag, "_enable"}, 256'(bus.mem_enable), 256'(0));
    checkOutput({tag, "_write"}, 256'(bus.mem_write), 256'(0));
    checkOutput({tag, "_addr"}, 256'(bus.mem_addr), 256'(0));
    checkOutput({tag, "_data"}, bus.mem_data, 256'(0));
  endtask

  task automatic clearInit();
    for (int s = 0; s < NS; s++)
      for (int w = 0; w < NW; w++) begin
        init_tag[s][w] = 25'(0);
        for (int k = 0; k < 8; k++) init_data[s][w][k*32 +: 32] = $urandom;
      end
  endtask

  task automatic randomInit();
    clearInit();
    for (int s = 0; s < NS; s++)
      for (int w = 0; w < NW; w++)
        init_tag[s][w] = {($urandom_range(0, 1) == 1), ($urandom_range(0, 2) == 0), 23'($urandom)};
  endtask

  initial begin
    int we0;
    int k;
    int idle;
    logic [IDX_W-1:0] s15;
    logic [WAY_W-1:0] w1;
    s15 = IDX_W'(15);
    w1  = WAY_W'(1);

    rst = 1'b0;
    repeat (3) @(negedge clk);
    checkIdleOutputs("reset");
    rst = 1'b1;

    // All entries invalid, some of them dirty: pure 3-cycle walk, no memory traffic.
    clearInit();
    for (int s = 0; s < NS; s++)
      for (int w = 0; w < NW; w++)
        init_tag[s][w] = {1'b0, ($urandom_range(0, 1) == 1), 23'($urandom)};
    applyStimulus(1'b0, 10, 1, 1'b0);
    waitDone(done_cnt + 1);
    checkOutput("allinv_busy_len", 256'(last_busy), 256'(97));
    checkFlush("allinv");

    // Single dirty line at set 3 way 1, clean mode.
    clearInit();
    init_tag[3][1]  = {1'b1, 1'b1, 23'h40};
    init_data[3][1] = {16{16'hECFA}};
    applyStimulus(1'b0, 10, 1, 1'b0);
    waitDone(done_cnt + 1);
    checkFlush("dirty1");
    checkOutput("dirty1_tag_const", 256'(tag_mem[3][1]), 256'({2'b10, 23'h40}));
    if (wr_log.size() > 0) checkOutput("dirty1_addr_const", 256'(wr_log[0].addr), 256'(32'h0000_8060));
    checkOutput("dirty1_count", 256'(wb_count), 256'(1));

    // Same line plus a valid clean line, invalidate mode.
    clearInit();
    init_tag[3][1]  = {1'b1, 1'b1, 23'h40};
    init_data[3][1] = {16{16'hECFA}};
    init_tag[0][0]  = {1'b1, 1'b0, 23'h1234};
    applyStimulus(1'b1, 10, 1, 1'b0);
    waitDone(done_cnt + 1);
    checkFlush("inv");
    checkOutput("inv_tag31", 256'(tag_mem[3][1]), 256'({2'b00, 23'h40}));
    checkOutput("inv_tag00", 256'(tag_mem[0][0]), 256'({2'b00, 23'h1234}));

    // First and last entries dirty: two writes in walk order.
    clearInit();
    init_tag[0][0]  = {1'b1, 1'b1, 23'h7};
    init_tag[15][1] = {1'b1, 1'b1, 23'h5A5A};
    applyStimulus(1'b0, $urandom_range(2, 12), 1, 1'b0);
    waitDone(done_cnt + 1);
    checkFlush("ends");
    checkOutput("ends_count", 256'(wb_count), 256'(2));
    if (wr_log.size() == 2) begin
      checkOutput("ends_first", 256'(wr_log[0].addr), 256'({23'h7, 4'd0, 5'd0}));
      checkOutput("ends_second", 256'(wr_log[1].addr), 256'({23'h5A5A, s15, 5'd0}));
    end

    // Reset in the middle of the first write-back, then a clean re-run.
    we0 = we_cnt;
    applyStimulus(1'b0, 10, 1, 1'b0);
    k = 0;
    while (!bus.mem_enable && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (!bus.mem_enable) reportFail("midwb_no_enable");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkIdleOutputs("midwb");
    checkOutput("midwb_no_we", 256'(we_cnt), 256'(we0));
    checkOutput("midwb_no_write", 256'(wr_log.size()), 256'(0));
    checkOutput("midwb_sram_kept", 256'(tag_mem[15][w1]), 256'(init_tag[15][1]));
    rst = 1'b1;
    applyStimulus(1'b0, 10, 1, 1'b0);
    waitDone(done_cnt + 1);
    checkFlush("rerun");

    // Request held high: exactly one re-arm after a single idle cycle.
    randomInit();
    applyStimulus(1'b0, $urandom_range(2, 6), 2, 1'b1);
    waitDone(done_cnt + 1);
    idle = 0;
    @(negedge clk);
    while (!flush_busy && idle < 10) begin
      idle++;
      @(negedge clk);
    end
    checkOutput("held_rearm_gap", 256'(idle), 256'(1));
    flush_req = 1'b0;
    waitDone(done_cnt + 1);
    repeat (5) @(negedge clk);
    checkOutput("held_no_third", 256'(flush_busy), 256'(0));
    checkFlush("held");

    // Randomized contents, mode and memory latency.
    for (int r = 0; r < 4; r++) begin
      randomInit();
      applyStimulus(($urandom_range(0, 1) == 1), $urandom_range(2, 12), 1, 1'b0);
      waitDone(done_cnt + 1);
      checkFlush("rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
